// File: rtl/dadda_pkg.sv
// Shared types and sizing helpers for the Dadda multiplier scheduler.
// The operand and response bundles carry the requester tag through the pipeline.
package dadda_pkg;

  localparam int N = 32;
  localparam int NUM_REQ = 4;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int ID_W = id_width(NUM_REQ);

  typedef struct packed {
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [ID_W-1:0] id;
  } mul_op_t;

  typedef struct packed {
    logic [2*N-1:0]  product;
    logic [ID_W-1:0] id;
  } mul_rsp_t;

endpackage

// File: rtl/dadda_mul_scheduler_if.sv
// Request and response channels of the shared multiplier scheduler.
// The master side is the client datapath; the slave side is the scheduler.
interface dadda_mul_scheduler_if #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [2*N-1:0]       rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );

endinterface

// File: rtl/dadda_mul_scheduler_multiplier.sv
// Unsigned N x N multiplier: partial products reduced by 3:2 carry-save
// layers until two rows remain, then one carry-propagate add.
module dadda_multiplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product
);

  localparam int W = 2 * N;

  logic [W-1:0] rows [N+2];
  logic [W-1:0] nxt  [N+2];
  int           cnt;
  int           o;

  always_comb begin
    for (int i = 0; i < N + 2; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      rows[i] = b[i] ? (W'(a) << i) : '0;
    end
    cnt = N;
    o   = 0;
    for (int lvl = 0; lvl < N; lvl++) begin
      if (cnt > 2) begin
        for (int i = 0; i < N + 2; i++) nxt[i] = '0;
        o = 0;
        for (int j = 0; j < N; j += 3) begin
          if (j + 2 < cnt) begin
            nxt[o] = rows[j] ^ rows[j+1] ^ rows[j+2];
            nxt[o+1] = ((rows[j] & rows[j+1]) |
                        (rows[j] & rows[j+2]) |
                        (rows[j+1] & rows[j+2])) << 1;
            o = o + 2;
          end else if (j < cnt) begin
            nxt[o] = rows[j];
            o = o + 1;
            if (j + 1 < cnt) begin
              nxt[o] = rows[j+1];
              o = o + 1;
            end
          end
        end
        rows = nxt;
        cnt  = o;
      end
    end
    // rows above cnt are zero, so a 1-row tail adds nothing
    product = rows[0] + rows[1];
  end

endmodule

// File: rtl/dadda_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// The one-hot grant is suppressed when en is low; idx still names the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic hit;
  int   p;

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    grant = '0;
    p     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = (int'(ptr) + k) % NUM_REQ;
      if (!hit && req[p]) begin
        hit = 1'b1;
        idx = ID_W'(p);
      end
    end
    if (hit && en) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dadda_mul_scheduler.sv
// Shares one multiplier among NUM_REQ requesters with round-robin grant.
// Two register stages: operands into the multiplier, tagged product out.
module dadda_mul_scheduler #(
  parameter int N       = dadda_pkg::N,
  parameter int NUM_REQ = dadda_pkg::NUM_REQ
) (
  input logic clk,
  input logic rst,
  dadda_mul_scheduler_if.slave bus
);

  import dadda_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  mul_op_t          s1;
  mul_rsp_t         s2;
  logic             s1_valid;
  logic             s2_valid;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   nxt_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [2*N-1:0]   product;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;

  assign s2_adv = !s2_valid || bus.rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (s1_adv),
    .grant (grant),
    .idx   (gidx)
  );

  // ready is held low while reset is asserted
  assign bus.req_ready = rst ? '0 : grant;
  assign accept = |(bus.req_valid & bus.req_ready);
  assign nxt_ptr = (int'(gidx) == NUM_REQ - 1)
                 ? '0 : gidx + 1'b1;

  dadda_multiplier #(
    .N (N)
  ) u_mul (
    .a       (s1.a),
    .b       (s1.b),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        s1.a     <= bus.req_a[gidx*N +: N];
        s1.b     <= bus.req_b[gidx*N +: N];
        s1.id    <= ID_W'(gidx);
        s1_valid <= 1'b1;
        rr_ptr   <= nxt_ptr;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2.product <= product;
          s2.id      <= s1.id;
        end
      end
    end
  end

  assign bus.rsp_valid   = s2_valid;
  assign bus.rsp_id      = IDW'(s2.id);
  assign bus.rsp_product = s2.product;

endmodule
